// File: rtl/sb_tx_msg_arbiter_if.sv
// sb_tx_msg_arbiter_if: encoder request/capture and serializer handshake bundle for the sideband TX arbiter
interface sb_tx_msg_arbiter_if;
  logic        i_ltsm_req;
  logic [63:0] i_ltsm_header;
  logic        i_ltsm_has_data;
  logic [63:0] i_ltsm_data;
  logic        o_ltsm_ack;
  logic        i_rdi_req;
  logic [63:0] i_rdi_header;
  logic        o_rdi_ack;
  logic        o_ser_valid;
  logic [63:0] o_ser_data;
  logic        i_ser_ready;
  logic        o_busy;
  modport master (
    input  i_ltsm_req, i_ltsm_header, i_ltsm_has_data, i_ltsm_data, i_rdi_req, i_rdi_header, i_ser_ready,
    output o_ltsm_ack, o_rdi_ack, o_ser_valid, o_ser_data, o_busy
  );
  modport slave (
    output i_ltsm_req, i_ltsm_header, i_ltsm_has_data, i_ltsm_data, i_rdi_req, i_rdi_header, i_ser_ready,
    input  o_ltsm_ack, o_rdi_ack, o_ser_valid, o_ser_data, o_busy
  );
endinterface

// File: rtl/sb_tx_msg_arbiter.sv
// sb_tx_msg_arbiter: round-robin share of the sideband serializer between LTSM and RDI encoders
module sb_tx_msg_arbiter #(
  parameter int GAP_CYCLES = 32
) (
  input logic               i_clk,
  input logic               i_rst_n,
  sb_tx_msg_arbiter_if.master bus
);
  localparam int CW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, HDR, DATA, GAP} state_t;
  localparam state_t AFTER = GAP_CYCLES == 0 ? IDLE : GAP;
  state_t        state_q, state_d;
  logic [63:0]   hdr_q, hdr_d, dat_q, dat_d, ser_data_q, ser_data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          has_q, has_d, rr_last_q, rr_last_d;
  logic          ltsm_ack_q, ltsm_ack_d, rdi_ack_q, rdi_ack_d;
  logic          ser_valid_q, ser_valid_d, busy_q, busy_d;
  logic          pick_ltsm;
  // rr_last_q=1 means RDI was granted last, so LTSM wins a tie
  assign pick_ltsm = bus.i_ltsm_req & (~bus.i_rdi_req | rr_last_q);
  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    dat_d      = dat_q;
    has_d      = has_q;
    rr_last_d  = rr_last_q;
    cnt_d      = cnt_q;
    ltsm_ack_d = 1'b0;
    rdi_ack_d  = 1'b0;
    case (state_q)
      IDLE: if (bus.i_ltsm_req | bus.i_rdi_req) begin
        state_d    = HDR;
        ltsm_ack_d = pick_ltsm;
        rdi_ack_d  = ~pick_ltsm;
        rr_last_d  = ~pick_ltsm;
        hdr_d      = pick_ltsm ? bus.i_ltsm_header : bus.i_rdi_header;
        has_d      = pick_ltsm & bus.i_ltsm_has_data;
        dat_d      = pick_ltsm ? bus.i_ltsm_data : '0;
      end
      HDR: if (bus.i_ser_ready) begin
        state_d = has_q ? DATA : AFTER;
        cnt_d   = has_q ? cnt_q : GAP_LOAD;
      end
      DATA: if (bus.i_ser_ready) begin
        state_d = AFTER;
        cnt_d   = GAP_LOAD;
      end
      default: begin
        state_d = cnt_q == '0 ? IDLE : GAP;
        cnt_d   = cnt_q == '0 ? '0 : cnt_q - CW'(1);
      end
    endcase
    ser_valid_d = state_d == HDR || state_d == DATA;
    ser_data_d  = state_d == HDR ? hdr_d : state_d == DATA ? dat_d : '0;
    busy_d      = state_d != IDLE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      hdr_q       <= '0;
      dat_q       <= '0;
      has_q       <= 1'b0;
      rr_last_q   <= 1'b1;
      cnt_q       <= '0;
      ltsm_ack_q  <= 1'b0;
      rdi_ack_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      dat_q       <= dat_d;
      has_q       <= has_d;
      rr_last_q   <= rr_last_d;
      cnt_q       <= cnt_d;
      ltsm_ack_q  <= ltsm_ack_d;
      rdi_ack_q   <= rdi_ack_d;
      ser_valid_q <= ser_valid_d;
      ser_data_q  <= ser_data_d;
      busy_q      <= busy_d;
    end
  end
  assign bus.o_ltsm_ack  = ltsm_ack_q;
  assign bus.o_rdi_ack   = rdi_ack_q;
  assign bus.o_ser_valid = ser_valid_q;
  assign bus.o_ser_data  = ser_data_q;
  assign bus.o_busy      = busy_q;
endmodule

// File: tb/tb_sb_tx_msg_arbiter.sv
// tb_sb_tx_msg_arbiter: directed vector table plus reset, round-robin and zero-gap sequences
module tb_sb_tx_msg_arbiter;
  localparam int G = 32;
  localparam logic [63:0] RH = 64'hA5A5_0000_0000_1234;
  localparam logic [63:0] LH = 64'h1111_1111_1111_1111;
  localparam logic [63:0] LD = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] X2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] X3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] H1 = 64'h0000_0000_0000_00A1;
  localparam logic [63:0] H2 = 64'h0000_0000_0000_00B2;
  localparam logic [63:0] H3 = 64'h0000_0000_0000_00C3;
  typedef struct {
    logic lreq; logic [63:0] lhdr; logic lhas; logic [63:0] ldat;
    logic rreq; logic [63:0] rhdr; logic rdy; int n;
    logic lack; logic rack; logic val; logic busy; logic [63:0] sdat;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vecs = 0;
  int errs = 0;
  vec_t vt[$];
  sb_tx_msg_arbiter_if b();
  sb_tx_msg_arbiter_if i0();
  sb_tx_msg_arbiter #(.GAP_CYCLES(G)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(b));
  sb_tx_msg_arbiter #(.GAP_CYCLES(0)) dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(i0));
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [67:0] got, logic [67:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  function automatic logic [67:0] outs();
    return {b.o_ltsm_ack, b.o_rdi_ack, b.o_ser_valid, b.o_busy, b.o_ser_data};
  endfunction
  task automatic drv(vec_t v);
    b.i_ltsm_req = v.lreq; b.i_ltsm_header = v.lhdr; b.i_ltsm_has_data = v.lhas;
    b.i_ltsm_data = v.ldat; b.i_rdi_req = v.rreq; b.i_rdi_header = v.rhdr; b.i_ser_ready = v.rdy;
  endtask
  initial begin
    int np, gapc;
    b.i_ltsm_req = 0; b.i_ltsm_header = 0; b.i_ltsm_has_data = 0; b.i_ltsm_data = 0;
    b.i_rdi_req = 0; b.i_rdi_header = 0; b.i_ser_ready = 0;
    i0.i_ltsm_req = 0; i0.i_ltsm_header = 0; i0.i_ltsm_has_data = 0; i0.i_ltsm_data = 0;
    i0.i_rdi_req = 0; i0.i_rdi_header = 0; i0.i_ser_ready = 0;
    vt.push_back('{0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0});
    vt.push_back('{0, 0, 0, 0, 1, RH, 1, 1, 0, 1, 1, 1, RH});
    vt.push_back('{0, 0, 0, 0, 0, RH, 1, G, 0, 0, 0, 1, 0});
    vt.push_back('{0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0});
    vt.push_back('{1, LH, 1, LD, 0, 0, 0, 1, 1, 0, 1, 1, LH});
    vt.push_back('{0, X2, 0, 0, 0, 0, 0, 5, 0, 0, 1, 1, LH});
    vt.push_back('{0, X2, 1, X3, 0, 0, 1, 1, 0, 0, 1, 1, LD});
    vt.push_back('{0, 0, 0, 0, 0, 0, 1, G, 0, 0, 0, 1, 0});
    vt.push_back('{0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0});
    #2;
    chk("reset_outs", outs(), 68'(0));
    @(negedge clk);
    rst_n = 1'b1;
    foreach (vt[i]) begin
      for (int k = 0; k < vt[i].n; k++) begin
        @(negedge clk);
        drv(vt[i]);
        @(posedge clk);
        #1;
        chk($sformatf("vec%0d_c%0d", i, k), outs(),
            {vt[i].lack, vt[i].rack, vt[i].val, vt[i].busy, vt[i].sdat});
      end
    end
    // reset asserted while the data word is on the bus
    @(negedge clk);
    drv('{1, LH, 1, LD, 0, 0, 1, 1, 0, 0, 0, 0, 0});
    @(negedge clk);
    b.i_ltsm_req = 0;
    @(posedge clk);
    #1;
    chk("pre_rst_data", outs(), {4'b0011, LD});
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", outs(), 68'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst_c%0d", k), outs(), 68'(0));
    end
    // both requests held: fair alternation starting with LTSM
    @(negedge clk);
    drv('{1, H1, 0, 0, 1, H2, 1, 1, 0, 0, 0, 0, 0});
    np = 0;
    gapc = 0;
    for (int c = 0; c < 400 && np < 4; c++) begin
      @(posedge clk);
      #1;
      if (b.o_ltsm_ack | b.o_rdi_ack) begin
        if (np > 0) chk($sformatf("rr_gap%0d", np), 68'(gapc), 68'(G));
        chk($sformatf("rr_ack%0d", np), 68'({b.o_ltsm_ack, b.o_rdi_ack}), 68'(np % 2 ? 2'b01 : 2'b10));
        chk($sformatf("rr_hdr%0d", np), 68'(b.o_ser_data), 68'(np % 2 ? H2 : H1));
        gapc = 0;
        np++;
      end else if (b.o_busy & ~b.o_ser_valid) gapc++;
    end
    chk("rr_count", 68'(np), 68'(4));
    @(negedge clk);
    b.i_ltsm_req = 0;
    b.i_rdi_req = 0;
    // zero gap: held RDI request alternates valid 1,0 with one ack per packet
    i0.i_rdi_req = 1;
    i0.i_rdi_header = H3;
    i0.i_ser_ready = 1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("zg_c%0d", k), {i0.o_rdi_ack, i0.o_ltsm_ack, i0.o_ser_valid, i0.o_busy, i0.o_ser_data},
          k % 2 == 0 ? {4'b1011, H3} : 68'(0));
    end
    @(negedge clk);
    i0.i_rdi_req = 0;
    repeat (40) @(posedge clk);
    #1;
    chk("final_idle", outs(), 68'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
